// File: rtl/pa_axil_arbiter_pkg.sv
// Shared types and constants for the two-requester AXI4-Lite register arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pa_axil_arbiter_pkg;

    // Transaction FSM; at most one AXI transaction is in flight.
    typedef enum logic [2:0] {
        IDLE,
        WR_REQ,
        WR_RESP,
        RD_REQ,
        RD_RESP
    } state_t;

    // AXI response codes
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Register bank byte offsets (four 32-bit registers)
    localparam logic [3:0] REG_OFF0 = 4'h0;
    localparam logic [3:0] REG_OFF1 = 4'h4;
    localparam logic [3:0] REG_OFF2 = 4'h8;
    localparam logic [3:0] REG_OFF3 = 4'hC;

endpackage

// File: rtl/pa_rr_arb2.sv
// Two-way round-robin arbiter: the requester not granted last has priority.
// Latency: grant is combinational from request; pointer updates on advance.
// Backpressure: none; caller asserts advance only when the grant is taken.
// Ports: ACLK/ARESET clock and sync reset, request[1:0] in, advance in,
//        grant[1:0] one-hot out (zero when nothing requests).
module pa_rr_arb2 (
    input  logic       ACLK,
    input  logic       ARESET,
    input  logic [1:0] request,
    input  logic       advance,
    output logic [1:0] grant
);

    // Index of the last granted requester; starts at 1 so requester 0 wins first.
    logic r_last;

    always_comb begin
        grant = 2'b00;
        case (request)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = r_last ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_last <= 1'b1;
        end else if (advance && (grant != 2'b00)) begin
            r_last <= grant[1];
        end
    end

endmodule

// File: rtl/pa_axil_arbiter.sv
// Arbitrates two simple command ports onto one AXI4-Lite master, one transaction at a time.
// Latency: grant same cycle as req_valid in IDLE; AXI valids one cycle later; rsp one cycle after B/R.
// Backpressure: req_ready only pulses in IDLE; AXI side waits on slave readies; rsp has none.
// Ports: req_* command inputs per requester (n at [n*W +: W]), req_ready grant pulse,
//        rsp_valid/rsp_rdata/rsp_resp completion, M_AXI_* AXI4-Lite master channels.
module pa_axil_arbiter
    import pa_axil_arbiter_pkg::*;
#(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 32
) (
    input  logic                  ACLK,
    input  logic                  ARESET,
    input  logic [1:0]            req_valid,
    output logic [1:0]            req_ready,
    input  logic [1:0]            req_we,
    input  logic [2*ADDR_W-1:0]   req_addr,
    input  logic [2*DATA_W-1:0]   req_wdata,
    output logic [1:0]            rsp_valid,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic [1:0]            rsp_resp,
    output logic [ADDR_W-1:0]     M_AXI_AWADDR,
    output logic [2:0]            M_AXI_AWPROT,
    output logic                  M_AXI_AWVALID,
    input  logic                  M_AXI_AWREADY,
    output logic [DATA_W-1:0]     M_AXI_WDATA,
    output logic [DATA_W/8-1:0]   M_AXI_WSTRB,
    output logic                  M_AXI_WVALID,
    input  logic                  M_AXI_WREADY,
    input  logic [1:0]            M_AXI_BRESP,
    input  logic                  M_AXI_BVALID,
    output logic                  M_AXI_BREADY,
    output logic [ADDR_W-1:0]     M_AXI_ARADDR,
    output logic [2:0]            M_AXI_ARPROT,
    output logic                  M_AXI_ARVALID,
    input  logic                  M_AXI_ARREADY,
    input  logic [DATA_W-1:0]     M_AXI_RDATA,
    input  logic [1:0]            M_AXI_RRESP,
    input  logic                  M_AXI_RVALID,
    output logic                  M_AXI_RREADY
);

    // Clears the two byte-lane bits so every access is word aligned.
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

    state_t              r_state;
    logic [1:0]          r_gnt;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic                r_aw_done;
    logic                r_w_done;

    logic [1:0]          w_grant;
    logic                w_idle_free;
    logic                w_take;
    logic                w_sel;
    logic                w_aw_hs;
    logic                w_w_hs;

    pa_rr_arb2 u_rr (
        .ACLK    (ACLK),
        .ARESET  (ARESET),
        .request (req_valid),
        .advance (w_take),
        .grant   (w_grant)
    );

    // Arbitration is held off in the cycle that presents a completion, so the
    // next grant lands in the IDLE cycle after rsp_valid.
    assign w_idle_free = (r_state == IDLE) && !ARESET && (rsp_valid == 2'b00);
    assign req_ready   = w_idle_free ? w_grant : 2'b00;
    assign w_take      = (req_ready != 2'b00);
    assign w_sel       = req_ready[1];

    assign w_aw_hs = M_AXI_AWVALID && M_AXI_AWREADY;
    assign w_w_hs  = M_AXI_WVALID && M_AXI_WREADY;

    assign M_AXI_AWADDR = r_addr & ALIGN_MASK;
    assign M_AXI_ARADDR = r_addr & ALIGN_MASK;
    assign M_AXI_AWPROT = 3'b000;
    assign M_AXI_ARPROT = 3'b000;
    assign M_AXI_WDATA  = r_wdata;
    assign M_AXI_WSTRB  = '1;

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_state       <= IDLE;
            r_gnt         <= 2'b00;
            r_addr        <= '0;
            r_wdata       <= '0;
            r_aw_done     <= 1'b0;
            r_w_done      <= 1'b0;
            rsp_valid     <= 2'b00;
            rsp_rdata     <= '0;
            rsp_resp      <= 2'b00;
            M_AXI_AWVALID <= 1'b0;
            M_AXI_WVALID  <= 1'b0;
            M_AXI_BREADY  <= 1'b0;
            M_AXI_ARVALID <= 1'b0;
            M_AXI_RREADY  <= 1'b0;
        end else begin
            rsp_valid <= 2'b00;
            case (r_state)
                IDLE: begin
                    if (w_take) begin
                        r_gnt     <= req_ready;
                        r_addr    <= w_sel ? req_addr[2*ADDR_W-1:ADDR_W] : req_addr[ADDR_W-1:0];
                        r_wdata   <= w_sel ? req_wdata[2*DATA_W-1:DATA_W] : req_wdata[DATA_W-1:0];
                        r_aw_done <= 1'b0;
                        r_w_done  <= 1'b0;
                        if (req_we[w_sel]) begin
                            M_AXI_AWVALID <= 1'b1;
                            M_AXI_WVALID  <= 1'b1;
                            r_state       <= WR_REQ;
                        end else begin
                            M_AXI_ARVALID <= 1'b1;
                            r_state       <= RD_REQ;
                        end
                    end
                end
                WR_REQ: begin
                    // AW and W complete independently, in either order.
                    if (w_aw_hs) begin
                        M_AXI_AWVALID <= 1'b0;
                        r_aw_done     <= 1'b1;
                    end
                    if (w_w_hs) begin
                        M_AXI_WVALID <= 1'b0;
                        r_w_done     <= 1'b1;
                    end
                    if ((r_aw_done || w_aw_hs) && (r_w_done || w_w_hs)) begin
                        M_AXI_BREADY <= 1'b1;
                        r_state      <= WR_RESP;
                    end
                end
                WR_RESP: begin
                    if (M_AXI_BVALID) begin
                        M_AXI_BREADY <= 1'b0;
                        rsp_valid    <= r_gnt;
                        rsp_resp     <= M_AXI_BRESP;
                        rsp_rdata    <= '0;
                        r_state      <= IDLE;
                    end
                end
                RD_REQ: begin
                    if (M_AXI_ARREADY) begin
                        M_AXI_ARVALID <= 1'b0;
                        M_AXI_RREADY  <= 1'b1;
                        r_state       <= RD_RESP;
                    end
                end
                RD_RESP: begin
                    if (M_AXI_RVALID) begin
                        M_AXI_RREADY <= 1'b0;
                        rsp_valid    <= r_gnt;
                        rsp_resp     <= M_AXI_RRESP;
                        rsp_rdata    <= M_AXI_RDATA;
                        r_state      <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
